// File: rtl/cic_decim_2bit.sv
// Third-order CIC decimator for the 16-bit modulator stream: three integrators at
// input rate, decimation by R, three unit-delay combs, top 16 bits for unity DC gain.
module cic_decim_2bit #(
    parameter int R = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic signed [15:0] v_lsli,
    input  logic               in_valid,
    input  logic               clr,
    output logic signed [15:0] v_dec,
    output logic               out_valid
);

    localparam int LOG2R = $clog2(R);
    localparam int ACC_W = 16 + 3 * LOG2R;
    localparam int CNT_W = LOG2R;

    logic [1:0]       sync_reg;
    logic             accept;
    logic             frame_last;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             strobe_reg;
    logic             comb_vld_reg;
    logic [15:0]      comb_out_reg;
    logic             out_valid_reg;
    logic [15:0]      v_dec_reg;

    logic [ACC_W-1:0] integ_in [3];
    logic [ACC_W-1:0] integ_q  [3];
    logic [ACC_W-1:0] comb_in  [4];
    logic             unused_low;

    // Release is synchronised; the gate opens as soon as the first stage sees it,
    // so the first sample is taken on the second edge after reset rises.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign accept     = in_valid & (|sync_reg) & ~clr;
    assign frame_last = (cnt_reg == CNT_W'(R - 1));
    assign cnt_next   = frame_last ? '0 : cnt_reg + 1'b1;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= accept & frame_last;
            if (accept) begin
                cnt_reg <= cnt_next;
            end
        end
    end

    assign integ_in[0] = {{(ACC_W - 16){v_lsli[15]}}, v_lsli};

    // Each integrator adds the registered output of the previous one (one-cycle skew).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_integ
            logic [ACC_W-1:0] acc_reg;

            if (gi > 0) begin : g_link
                assign integ_in[gi] = integ_q[gi-1];
            end

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    acc_reg <= '0;
                end else if (clr) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= acc_reg + integ_in[gi];
                end
            end

            assign integ_q[gi] = acc_reg;
        end
    endgenerate

    assign comb_in[0] = integ_q[2];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_comb
            logic [ACC_W-1:0] dly_reg;

            assign comb_in[gi+1] = comb_in[gi] - dly_reg;

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    dly_reg <= '0;
                end else if (clr) begin
                    dly_reg <= '0;
                end else if (strobe_reg) begin
                    dly_reg <= comb_in[gi];
                end
            end
        end
    endgenerate

    assign unused_low = ^comb_in[3][ACC_W-17:0];

    // Comb result is registered, then published one edge later with out_valid.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            comb_vld_reg  <= 1'b0;
            comb_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            v_dec_reg     <= '0;
        end else if (clr) begin
            comb_vld_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            comb_vld_reg  <= strobe_reg;
            out_valid_reg <= comb_vld_reg;
            if (strobe_reg) begin
                comb_out_reg <= comb_in[3][ACC_W-1 -: 16];
            end
            if (comb_vld_reg) begin
                v_dec_reg <= comb_out_reg;
            end
        end
    end

    assign v_dec     = v_dec_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cic_decim_2bit.sv
// Randomised bench for cic_decim_2bit: a closed-form CIC model (weighted sums of the
// accepted samples, third difference per frame) predicts every out_valid and v_dec.
module tb_cic_decim_2bit;

    localparam int R     = 16;
    localparam int ACC_W = 16 + 3 * $clog2(R);

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] v_lsli;
    logic        in_valid;
    logic        clr;
    logic [15:0] v_dec;
    logic        out_valid;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rel   = 0;
    longint      samp[$];
    int          due_q[$];
    logic [15:0] val_q[$];
    logic [15:0] exp_vdec = 16'h0000;

    cic_decim_2bit #(.R(R)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .v_lsli    (v_lsli),
        .in_valid  (in_valid),
        .clr       (clr),
        .v_dec     (v_dec),
        .out_valid (out_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Integrator-3 after the N-th sample is sum x[k]*(N-k)(N-k-1)/2; the combs take
    // a third difference over frame boundaries, all modulo 2^ACC_W.
    function automatic logic [15:0] calc();
        int     nf;
        int     m;
        longint n;
        longint y[4];
        longint c;
        longint mask;
        nf = samp.size() / R;
        for (int j = 0; j < 4; j++) begin
            y[j] = 0;
            m = nf - j;
            if (m >= 1) begin
                n = longint'(m * R - 1);
                for (int k = 0; k <= n; k++) begin
                    y[j] += samp[k] * ((n - k) * (n - k - 1) / 2);
                end
            end
        end
        c    = y[0] - 3 * y[1] + 3 * y[2] - y[3];
        mask = (longint'(1) <<< ACC_W) - 1;
        c    = c & mask;
        return 16'(c >>> (ACC_W - 16));
    endfunction

    task automatic step(input logic iv, input logic [15:0] d, input logic c);
        logic ev;
        in_valid = iv;
        v_lsli   = d;
        clr      = c;
        @(posedge CLK);
        cyc++;
        if (reset) begin
            if (rel < 2) rel++;
            if (c) begin
                samp.delete();
                due_q.delete();
                val_q.delete();
            end else if (iv && rel >= 2) begin
                samp.push_back(longint'($signed(d)));
                if (samp.size() % R == 0) begin
                    due_q.push_back(cyc + 2);
                    val_q.push_back(calc());
                end
            end
        end
        #1;
        ev = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            ev       = 1'b1;
            exp_vdec = val_q.pop_front();
            void'(due_q.pop_front());
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("v_dec", {16'b0, v_dec}, {16'b0, exp_vdec});
        if (out_valid) $display("cycle %0d: out_valid v_dec=%h", cyc, v_dec);
    endtask

    task automatic run_const(input logic [15:0] d, input int period, input int nframes);
        int pn;
        int prev;
        int span;
        pn   = 0;
        prev = 0;
        span = nframes * R * period;
        for (int i = 0; i < span + 4; i++) begin
            step((i < span) && (i % period == 0), d, 1'b0);
            if (out_valid) begin
                pn++;
                if (pn >= 3) chk("dc_level", {16'b0, v_dec}, {16'b0, d});
                if (pn >= 2) chk("pulse_spacing", cyc - prev, R * period);
                prev = cyc;
            end
        end
        chk("pulse_count", pn, nframes);
        step(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        samp.delete();
        due_q.delete();
        val_q.delete();
        exp_vdec = 16'h0000;
        rel      = 0;
        repeat (3) step(1'b1, 16'($urandom), 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        int np;
        reset    = 1'b1;
        in_valid = 1'b0;
        v_lsli   = 16'h0000;
        clr      = 1'b0;
        #3 reset = 1'b0;

        // Held in reset with traffic present: outputs stay cleared.
        repeat (5) step(1'b1, 16'h1234, 1'b0);
        reset = 1'b1;

        // First edge after release is ignored; 16 accepted samples give one pulse.
        repeat (17) step(1'b1, 16'($urandom), 1'b0);
        repeat (4) step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);

        run_const(16'h1000, 1, 5);
        run_const(16'h8000, 1, 5);
        run_const(16'h7FFF, 1, 5);
        run_const(16'h1000, 3, 5);

        // clr with the 10th sample: no pulse until 16 further samples.
        np = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'($urandom), 1'b0);
            if (out_valid) np++;
        end
        step(1'b1, 16'h7ABC, 1'b1);
        if (out_valid) np++;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 16'($urandom), 1'b0);
            if (out_valid) np++;
        end
        chk("clr_no_pulse", np, 0);
        np = 0;
        step(1'b1, 16'($urandom), 1'b0);
        repeat (3) begin
            step(1'b0, 16'h0000, 1'b0);
            if (out_valid) np++;
        end
        chk("clr_one_pulse", np, 1);

        // Random traffic with gaps and occasional clr.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 70, 16'($urandom), $urandom_range(299) == 0);
        end

        // Reset mid-frame discards the partial frame.
        repeat (7) step(1'b1, 16'($urandom), 1'b0);
        pulse_reset();
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(99) < 80, 16'($urandom), 1'b0);
        end
        repeat (4) step(1'b0, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_decim_2bit.md
CIC_DECIM_2BIT -- requirements
Module: cic_decim_2bit

Interface
REQ-001 SHALL have parameter R, default 16, meaning decimation ratio; legal values 4, 8, 16, 32 only.
REQ-002 SHALL have derived localparam ACC_W = 16 + 3*log2(R), meaning integrator/comb register width (28 at R=16).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-005 SHALL have port v_lsli  input  16  signed two's-complement modulator sample from matlab_2bit.
REQ-006 SHALL have port in_valid  input  1  v_lsli is accepted on a rising edge where in_valid=1.
REQ-007 SHALL have port clr  input  1  synchronous clear of filter state, active-high.
REQ-008 SHALL have port v_dec  output  16  signed decimated sample.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse marking a new v_dec.

Function
REQ-010 SHALL implement a 3rd-order CIC decimator: three cascaded integrators at input rate, decimate by R, three cascaded first-difference combs (differential delay 1) at output rate.
REQ-011 SHALL sign-extend v_lsli to ACC_W bits before integrator 1.
REQ-012 SHALL update all three integrators only on edges with in_valid=1; integrator k+1 adds the registered value of integrator k (one-cycle skew per stage).
REQ-013 SHALL perform all integrator and comb arithmetic modulo 2^ACC_W; wrap-around is intended and no saturation or overflow flag exists.
REQ-014 SHALL keep a phase counter 0..R-1 advancing by one per accepted sample, wrapping R-1 -> 0.
REQ-015 SHALL assert an internal decimation strobe on the edge that accepts a sample while the counter equals R-1.
REQ-016 SHALL, on the cycle after that strobe, run the comb chain on integrator-3 output, update the three comb delay registers, and register the result.
REQ-017 SHALL drive v_dec = comb-3 result bits [ACC_W-1 : ACC_W-16], giving unity DC gain.
REQ-018 SHALL assert out_valid for exactly one cycle, on the 2nd rising edge after the edge accepting the R-th sample; v_dec holds its value until the next out_valid.
REQ-019 SHALL make outputs independent of idle gaps: any in_valid=0 cycles between samples leave v_dec values unchanged.
REQ-020 SHALL, when clr=1, zero integrators, combs, counter and pending strobe on that edge, force out_valid=0, and keep v_dec at its last value; clr takes priority over a simultaneous in_valid.
REQ-021 SHALL accept back-to-back in_valid=1 every cycle; no backpressure exists.

Reset
REQ-022 SHALL, while reset=0, hold v_dec=16'h0000, out_valid=0, counter=0, all integrator and comb registers 0.
REQ-023 SHALL, when reset asserts mid-frame, discard the partial frame and any pending strobe; the first out_valid after release requires R fresh accepted samples.
REQ-024 SHALL synchronise reset deassertion internally (2-flop) so the first accepted sample is on the 2nd edge after reset rises.

Verification
REQ-025 Reset: hold reset=0, toggle CLK, drive in_valid=1 -> v_dec=16'h0000 and out_valid=0 throughout.
REQ-026 DC: R=16, v_lsli=16'h1000 with in_valid=1 every cycle -> out_valid every 16 cycles; from the 3rd pulse onward v_dec=16'h1000.
REQ-027 Extremes: v_lsli=16'h8000 constant -> v_dec=16'h8000 from the 3rd pulse; v_lsli=16'h7FFF -> v_dec=16'h7FFF (wrap arithmetic exact).
REQ-028 Gaps: repeat REQ-026 with in_valid=1 one cycle in three -> identical v_dec sequence; out_valid spacing 48 cycles.
REQ-029 Latency: from reset release, feed 16 samples -> out_valid rises on the 2nd edge after the 16th acceptance, exactly one cycle wide.
REQ-030 clr: assert clr together with the 10th sample of a frame -> that sample is ignored, no out_valid, next out_valid after 16 further samples, v_dec held meanwhile.
